// File: rtl/seg7_pkg.sv
// Shared constants for the decimal 7-segment scanner: active-low segment
// patterns (g..a), converter state encoding and small elaboration helpers.
package seg7_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001,
    7'b001_0010, 7'b000_0010, 7'b111_1000, 7'b000_0000, 7'b001_0000
  };
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  // Non-decimal nibbles cannot come out of the converter; map them to dash anyway.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = SEG_DIGIT[0];
      4'd1:    seg_encode = SEG_DIGIT[1];
      4'd2:    seg_encode = SEG_DIGIT[2];
      4'd3:    seg_encode = SEG_DIGIT[3];
      4'd4:    seg_encode = SEG_DIGIT[4];
      4'd5:    seg_encode = SEG_DIGIT[5];
      4'd6:    seg_encode = SEG_DIGIT[6];
      4'd7:    seg_encode = SEG_DIGIT[7];
      4'd8:    seg_encode = SEG_DIGIT[8];
      4'd9:    seg_encode = SEG_DIGIT[9];
      default: seg_encode = SEG_DASH;
    endcase
  endfunction

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, re-converts whenever
// the input differs from the last converted value.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 13,
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     value,
  output logic                    done,
  output logic [4*N_DIGITS-1:0]   bcd,
  output logic                    overflow
);

  localparam int unsigned BCD_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [31:0] LIMIT = pow10(N_DIGITS);

  conv_state_t          state, state_next;
  logic [IN_WIDTH-1:0]  latched, shreg, last_converted;
  logic [CNT_W-1:0]     bit_cnt;
  logic [BCD_W-1:0]     bcd_q, bcd_adj, bcd_shifted;
  logic                 launch;

  assign launch = start && (value != last_converted);

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    // Bits shifted past the top nibble are dropped; overflow flags that case.
    bcd_shifted = {bcd_adj[BCD_W-2:0], shreg[IN_WIDTH-1]};
  end

  always_comb begin
    state_next = state;
    case (state)
      CONV_IDLE:  if (launch) state_next = CONV_SHIFT;
      CONV_SHIFT: if (bit_cnt == CNT_W'(IN_WIDTH - 1)) state_next = CONV_DONE;
      CONV_DONE:  state_next = CONV_IDLE;
      default:    state_next = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CONV_IDLE;
      latched        <= '0;
      shreg          <= '0;
      last_converted <= '0;
      bit_cnt        <= '0;
      bcd_q          <= '0;
    end else begin
      state <= state_next;
      case (state)
        CONV_IDLE: if (launch) begin
          latched <= value;
          shreg   <= value;
          bcd_q   <= '0;
          bit_cnt <= '0;
        end
        CONV_SHIFT: begin
          bcd_q   <= bcd_shifted;
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        CONV_DONE: last_converted <= latched;
        default: ;
      endcase
    end
  end

  assign done     = (state == CONV_DONE);
  assign bcd      = bcd_q;
  assign overflow = (32'(latched) >= LIMIT);

endmodule

// File: rtl/seg7_decimal_scanner.sv
// Multiplexed common-anode decimal display driver: BCD conversion, digit scan,
// leading-zero blanking, decimal points and overflow dashes.
module seg7_decimal_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned IN_WIDTH    = 13,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  value,
  input  logic [N_DIGITS-1:0]  dp_mask,
  output logic [6:0]           segmentDisplay,
  output logic [N_DIGITS-1:0]  an,
  output logic                 dp,
  output logic                 overflow
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0]        refresh_cnt;
  logic [IDX_W-1:0]        scan_idx;
  logic [4*N_DIGITS-1:0]   disp_bcd, conv_bcd;
  logic                    disp_ovf, conv_ovf, conv_done;

  logic [6:0]              seg_next;
  logic [N_DIGITS-1:0]     an_next;
  logic                    dp_next;
  logic [3:0]              digit;
  logic                    hi_nz, blank;
  int unsigned             idx_u;

  bin2bcd_seq #(
    .IN_WIDTH (IN_WIDTH),
    .N_DIGITS (N_DIGITS)
  ) u_conv (
    .clk      (clk),
    .reset    (reset),
    .start    (1'b1),
    .value    (value),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  // Digit i is blank when it and every digit above it are zero.
  always_comb begin
    idx_u   = 32'(scan_idx);
    digit   = '0;
    hi_nz   = 1'b0;
    an_next = '1;
    dp_next = 1'b1;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (j == idx_u) begin
        digit      = disp_bcd[4*j +: 4];
        an_next[j] = 1'b0;
        dp_next    = ~dp_mask[j];
      end
      if (j >= idx_u) hi_nz = hi_nz | (|disp_bcd[4*j +: 4]);
    end
    blank = (BLANK_LZ != 0) && (idx_u != 0) && !hi_nz;
    if (disp_ovf)   seg_next = SEG_DASH;
    else if (blank) seg_next = SEG_BLANK;
    else            seg_next = seg_encode(digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt    <= '0;
      scan_idx       <= '0;
      disp_bcd       <= '0;
      disp_ovf       <= 1'b0;
      segmentDisplay <= SEG_BLANK;
      an             <= '1;
      dp             <= 1'b1;
      overflow       <= 1'b0;
    end else begin
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        scan_idx    <= (scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      if (conv_done) begin
        disp_bcd <= conv_bcd;
        disp_ovf <= conv_ovf;
      end
      segmentDisplay <= seg_next;
      an             <= an_next;
      dp             <= dp_next;
      overflow       <= disp_ovf;
    end
  end

endmodule

// File: tb/tb_seg7_decimal_scanner.sv
// Directed bench for seg7_decimal_scanner: three configurations, scanned digits
// captured per anode and compared against hand-computed segment patterns.
module tb_seg7_decimal_scanner;

  localparam logic [6:0] S0 = 7'b100_0000, S1 = 7'b111_1001, S2 = 7'b010_0100,
                         S3 = 7'b011_0000, S4 = 7'b001_1001, S5 = 7'b001_0010,
                         S6 = 7'b000_0010, S7 = 7'b111_1000, S8 = 7'b000_0000,
                         S9 = 7'b001_0000, SB = 7'b111_1111, SD = 7'b011_1111;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] value;
  logic [9:0]  value2;
  logic [3:0]  dp_mask;
  logic [2:0]  dp_mask2;
  logic [6:0]  seg0, seg1, seg2;
  logic [3:0]  an0, an1;
  logic [2:0]  an2;
  logic        dp0, dp1, dp2, ovf0, ovf1, ovf2;

  int checks = 0;
  int failures = 0;

  logic [6:0] cap0 [4];
  logic [6:0] cap1 [4];
  logic [6:0] cap2 [3];

  always #5 clk = ~clk;

  seg7_decimal_scanner #(.N_DIGITS(4), .IN_WIDTH(13), .REFRESH_DIV(4), .BLANK_LZ(1)) u0 (
    .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask),
    .segmentDisplay(seg0), .an(an0), .dp(dp0), .overflow(ovf0));

  seg7_decimal_scanner #(.N_DIGITS(4), .IN_WIDTH(13), .REFRESH_DIV(4), .BLANK_LZ(0)) u1 (
    .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask),
    .segmentDisplay(seg1), .an(an1), .dp(dp1), .overflow(ovf1));

  seg7_decimal_scanner #(.N_DIGITS(3), .IN_WIDTH(10), .REFRESH_DIV(4), .BLANK_LZ(1)) u2 (
    .clk(clk), .reset(reset), .value(value2), .dp_mask(dp_mask2),
    .segmentDisplay(seg2), .an(an2), .dp(dp2), .overflow(ovf2));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two full scan rotations; a digit never seen stays X.
  task automatic scan_all();
    for (int d = 0; d < 4; d++) begin cap0[d] = 'x; cap1[d] = 'x; end
    for (int d = 0; d < 3; d++) cap2[d] = 'x;
    repeat (36) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (an0 == ~(4'b0001 << d)) cap0[d] = seg0;
        if (an1 == ~(4'b0001 << d)) cap1[d] = seg1;
      end
      for (int d = 0; d < 3; d++)
        if (an2 == ~(3'b001 << d)) cap2[d] = seg2;
    end
  endtask

  task automatic test_reset();
    logic [3:0] seq [$];
    logic [3:0] prev;
    logic [3:0] exp_seq [4];
    exp_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset = 1'b1; value = '0; value2 = '0; dp_mask = '0; dp_mask2 = '0;
    tick(3);
    checks++; if (seg0 !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%b exp=%b", seg0, 7'h7F); end
    checks++; if (an0 !== 4'hF) begin failures++; $display("FAIL reset_an got=%b exp=%b", an0, 4'hF); end
    checks++; if (dp0 !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp0); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf0); end
    @(negedge clk);
    reset = 1'b0;
    prev = 4'hF;
    repeat (17) begin
      @(negedge clk);
      if (an0 !== prev) begin seq.push_back(an0); prev = an0; end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seq.size() <= i || seq[i] !== exp_seq[i]) begin
        failures++;
        $display("FAIL an_order[%0d] got=%b exp=%b", i, (seq.size() > i) ? seq[i] : 4'bx, exp_seq[i]);
      end
    end
    tick(15);
    scan_all();
    checks++; if (cap0[0] !== S0) begin failures++; $display("FAIL zero_d0 got=%b exp=%b", cap0[0], S0); end
    for (int d = 1; d < 4; d++) begin
      checks++; if (cap0[d] !== SB) begin failures++; $display("FAIL zero_blank_d%0d got=%b exp=%b", d, cap0[d], SB); end
    end
    checks++; if (dp0 !== 1'b1) begin failures++; $display("FAIL zero_dp got=%b exp=1", dp0); end
  endtask

  task automatic test_digits();
    logic [6:0] e0 [4];
    value = 13'd1234; tick(20); scan_all();
    e0 = '{S4, S3, S2, S1};
    for (int d = 0; d < 4; d++) begin
      checks++; if (cap0[d] !== e0[d]) begin failures++; $display("FAIL v1234_d%0d got=%b exp=%b", d, cap0[d], e0[d]); end
    end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL v1234_ovf got=%b exp=0", ovf0); end

    value = 13'd6789; tick(20); scan_all();
    e0 = '{S9, S8, S7, S6};
    for (int d = 0; d < 4; d++) begin
      checks++; if (cap0[d] !== e0[d]) begin failures++; $display("FAIL v6789_d%0d got=%b exp=%b", d, cap0[d], e0[d]); end
    end

    value = 13'd105; tick(20); scan_all();
    e0 = '{S5, S0, S1, SB};
    for (int d = 0; d < 4; d++) begin
      checks++; if (cap0[d] !== e0[d]) begin failures++; $display("FAIL v105_lz_d%0d got=%b exp=%b", d, cap0[d], e0[d]); end
    end
    e0 = '{S5, S0, S1, S0};
    for (int d = 0; d < 4; d++) begin
      checks++; if (cap1[d] !== e0[d]) begin failures++; $display("FAIL v105_nolz_d%0d got=%b exp=%b", d, cap1[d], e0[d]); end
    end
  endtask

  task automatic test_overflow();
    value2 = 10'd1000; tick(20); scan_all();
    checks++; if (ovf2 !== 1'b1) begin failures++; $display("FAIL ovf1000 got=%b exp=1", ovf2); end
    for (int d = 0; d < 3; d++) begin
      checks++; if (cap2[d] !== SD) begin failures++; $display("FAIL ovf1000_d%0d got=%b exp=%b", d, cap2[d], SD); end
    end
    value2 = 10'd999; tick(20); scan_all();
    checks++; if (ovf2 !== 1'b0) begin failures++; $display("FAIL v999_ovf got=%b exp=0", ovf2); end
    for (int d = 0; d < 3; d++) begin
      checks++; if (cap2[d] !== S9) begin failures++; $display("FAIL v999_d%0d got=%b exp=%b", d, cap2[d], S9); end
    end
  endtask

  task automatic test_dp();
    logic exp_dp;
    dp_mask = 4'b0100; tick(2);
    repeat (16) begin
      @(negedge clk);
      exp_dp = (an0 == 4'b1011) ? 1'b0 : 1'b1;
      checks++; if (dp0 !== exp_dp) begin failures++; $display("FAIL dp an=%b got=%b exp=%b", an0, dp0, exp_dp); end
    end
    dp_mask = '0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] e0 [4];
    value = 13'd100; tick(20);
    value = 13'd1234; tick(3);
    value = 13'd4321; tick(40); scan_all();
    e0 = '{S1, S2, S3, S4};
    for (int d = 0; d < 4; d++) begin
      checks++; if (cap0[d] !== e0[d]) begin failures++; $display("FAIL b2b_d%0d got=%b exp=%b", d, cap0[d], e0[d]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e0 [4];
    value = 13'd1234; tick(20);
    value = 13'd4321; tick(5);
    reset = 1'b1; tick(1);
    checks++; if (seg0 !== 7'h7F) begin failures++; $display("FAIL midrst_seg got=%b exp=%b", seg0, 7'h7F); end
    checks++; if (an0 !== 4'hF) begin failures++; $display("FAIL midrst_an got=%b exp=%b", an0, 4'hF); end
    checks++; if (dp0 !== 1'b1) begin failures++; $display("FAIL midrst_dp got=%b exp=1", dp0); end
    reset = 1'b0; tick(20); scan_all();
    e0 = '{S1, S2, S3, S4};
    for (int d = 0; d < 4; d++) begin
      checks++; if (cap0[d] !== e0[d]) begin failures++; $display("FAIL midrst_d%0d got=%b exp=%b", d, cap0[d], e0[d]); end
    end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL midrst_ovf got=%b exp=0", ovf0); end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_overflow();
    test_dp();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
